// File: rtl/store_write_buffer_pkg.sv
// mips_wb_defs: shared defaults and drain-FSM encoding for the store write buffer.
// Contents: WB_DEPTH/WB_AW/WB_DW parameter defaults, wb_state_t (IDLE, REQ).
package mips_wb_defs;
    localparam int WB_DEPTH = 4;
    localparam int WB_AW    = 32;
    localparam int WB_DW    = 32;
    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} wb_state_t;
endpackage

// File: rtl/store_write_buffer_fifo.sv
// wb_fifo: store storage array with pointers and occupancy count.
// Ports: clk, reset (async, active-high); push/pop requests (ignored when full/empty);
//        wr_addr/wr_data entry to append; full, empty, count status;
//        head_addr/head_data entry at rd_ptr.
// Optional (WB_COALESCE_EN): overwrite replaces tail data with wr_data; tail_addr exposes tail address.
module wb_fifo
    import mips_wb_defs::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DW-1:0]            wr_data,
`ifdef WB_COALESCE_EN
    input  logic                     overwrite,
    output logic [AW-1:0]            tail_addr,
`endif
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [AW-1:0]            head_addr,
    output logic [DW-1:0]            head_data
);
    localparam int PW = $clog2(DEPTH);
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign full      = count == (PW+1)'(DEPTH);
    assign empty     = count == '0;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];
`ifdef WB_COALESCE_EN
    logic [PW-1:0] tail_ptr;
    assign tail_ptr  = wr_ptr - 1'b1;
    assign tail_addr = addr_q[tail_ptr];
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                addr_q[wr_ptr] <= wr_addr;
                data_q[wr_ptr] <= wr_data;
                wr_ptr         <= wr_ptr + 1'b1;
            end
`ifdef WB_COALESCE_EN
            if (overwrite)
                data_q[tail_ptr] <= wr_data;
`endif
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/store_write_buffer.sv
// store_write_buffer: buffers core stores in a FIFO and drains them to slow memory via req/ack.
// Ports: clk, reset (async, active-high); memwrite/dataadr/writedata core store port;
//        stall (buffer full, core holds store), empty, count; mem_req/mem_addr/mem_wdata
//        drain request carrying the head entry; mem_ack memory accepted the head this cycle.
// Macro WB_COALESCE_EN: a store hitting the tail address (tail not the in-flight head)
// merges its data into the tail instead of allocating, and is accepted even when full.
module store_write_buffer
    import mips_wb_defs::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwrite,
    input  logic [AW-1:0]            dataadr,
    input  logic [DW-1:0]            writedata,
    output logic                     stall,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     mem_req,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ack
);
    localparam int CW = $clog2(DEPTH) + 1;
    wb_state_t state, state_next;
    logic      full, push, pop;
    assign pop = (state == REQ) && mem_ack;
`ifdef WB_COALESCE_EN
    logic [AW-1:0] tail_addr;
    logic          coal;
    // with a single entry in REQ the tail is the head already on the bus, so it must not change
    assign coal  = memwrite && !empty && (dataadr == tail_addr) && !((state == REQ) && (count == CW'(1)));
    assign stall = full && !coal;
    assign push  = memwrite && !full && !coal;
`else
    assign stall = full;
    assign push  = memwrite && !full;
`endif
    wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .wr_addr   (dataadr),
        .wr_data   (writedata),
`ifdef WB_COALESCE_EN
        .overwrite (coal),
        .tail_addr (tail_addr),
`endif
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head_addr (mem_addr),
        .head_data (mem_wdata)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end
    // staying in REQ when another entry remains after the pop gives bubble-free drains
    always_comb begin
        state_next = state;
        mem_req    = state == REQ;
        state_next = (state == IDLE) ? (empty ? IDLE : REQ)
                   : (mem_ack && !(count > CW'(1)) && !push) ? IDLE : REQ;
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed self-checking bench for store_write_buffer
module tb_store_write_buffer;
  logic clk = 0;
  logic reset, memwrite, mem_ack;
  logic [31:0] dataadr, writedata;
  logic stall, empty, mem_req;
  logic [2:0] count;
  logic [31:0] mem_addr, mem_wdata;
  int checks = 0;
  int failures = 0;
  int writes = 0;
  logic [31:0] exp_a [4];
  store_write_buffer dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .stall(stall), .empty(empty), .count(count), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_req && mem_ack && !reset) writes++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1; dataadr = a; writedata = d;
    step();
  endtask
  initial begin
    reset = 1; memwrite = 0; mem_ack = 0; dataadr = 0; writedata = 0;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    step(); step();
    reset = 0;
    mem_ack = 1;
    store(32'h52, 32'hFFFF7F02);
    memwrite = 0;
    check("t1_count", count, 1);
    check("t1_req_lat", mem_req, 0);
    step();
    check("t1_req", mem_req, 1);
    check("t1_addr", mem_addr, 32'h52);
    check("t1_wdata", mem_wdata, 32'hFFFF7F02);
    step();
    check("t1_empty", empty, 1);
    check("t1_req_drop", mem_req, 0);
    check("t1_writes", writes, 1);
    mem_ack = 0;
    exp_a = '{32'h50, 32'h54, 32'h58, 32'h5C};
    for (int i = 0; i < 4; i++) store(exp_a[i], exp_a[i] + 32'h100);
    memwrite = 0;
    check("t2_count_full", count, 4);
    check("t2_stall", stall, 1);
    check("t2_req_hold", mem_req, 1);
    check("t2_head_hold", mem_addr, 32'h50);
    store(32'h70, 32'h170);
    memwrite = 0;
    check("t2_refused", count, 4);
    mem_ack = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_req", mem_req, 1);
      check("t2_drain_addr", mem_addr, exp_a[i]);
      check("t2_drain_data", mem_wdata, exp_a[i] + 32'h100);
      step();
    end
    check("t2_empty", empty, 1);
    check("t2_idle", mem_req, 0);
    mem_ack = 0;
    exp_a = '{32'h84, 32'h88, 32'h8C, 32'h90};
    store(32'h80, 32'h1); store(32'h84, 32'h2); store(32'h88, 32'h3); store(32'h8C, 32'h4);
    memwrite = 1; dataadr = 32'h90; writedata = 32'h5; mem_ack = 1;
    #1;
    check("t3_stall_full", stall, 1);
    step();
    mem_ack = 0;
    check("t3_count_pop", count, 3);
    check("t3_stall_clear", stall, 0);
    step();
    memwrite = 0;
    check("t3_count_refill", count, 4);
    mem_ack = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t3_drain_addr", mem_addr, exp_a[i]);
      check("t3_drain_data", mem_wdata, 32'(i + 2));
      step();
    end
    check("t3_empty", empty, 1);
    mem_ack = 0;
    store(32'hA0, 32'hA); store(32'hA4, 32'hB); store(32'hA8, 32'hC);
    memwrite = 0;
    check("t4_count", count, 3);
    check("t4_req", mem_req, 1);
    writes = 0;
    #2 reset = 1;
    #1;
    check("t4_req_async", mem_req, 0);
    check("t4_count_async", count, 0);
    check("t4_addr_async", mem_addr, 0);
    mem_ack = 1;
    step();
    reset = 0;
    step(); step();
    check("t4_no_req", mem_req, 0);
    check("t4_no_writes", writes, 0);
    mem_ack = 0;
    store(32'h40, 32'h11); store(32'h60, 32'h1); store(32'h60, 32'h5);
    memwrite = 0;
`ifdef WB_COALESCE_EN
    check("t5_count", count, 2);
`else
    check("t5_count", count, 3);
`endif
    mem_ack = 1;
    #1;
    check("t5_addr0", mem_addr, 32'h40);
    check("t5_data0", mem_wdata, 32'h11);
    step();
    check("t5_addr1", mem_addr, 32'h60);
`ifdef WB_COALESCE_EN
    check("t5_data1", mem_wdata, 32'h5);
    step();
`else
    check("t5_data1", mem_wdata, 32'h1);
    step();
    check("t5_addr2", mem_addr, 32'h60);
    check("t5_data2", mem_wdata, 32'h5);
    step();
`endif
    check("t5_empty", empty, 1);
    check("t5_idle", mem_req, 0);
    mem_ack = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Downstream stage of the single-cycle MIPS core's data-memory write port (memwrite / dataadr / writedata).
- Captures every store into a small FIFO and drains it to a slower memory over a req/ack handshake, so the core stalls only when the buffer is full.
- Sits between the core's data-memory interface and the external/slow data memory.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- memwrite  input  1  core store strobe, sampled on rising clk.
- dataadr  input  AW  store address from core.
- writedata  input  DW  store data from core.
- stall  output  1  buffer full; the core must hold the current store.
- empty  output  1  no entries pending.
- count  output  $clog2(DEPTH)+1  entries currently held.
- mem_req  output  1  drain request to memory.
- mem_addr  output  AW  address of head entry.
- mem_wdata  output  DW  data of head entry.
- mem_ack  input  1  memory accepted the head entry this cycle.

Behaviour:
- Reset (asynchronous): wr_ptr=0, rd_ptr=0, count=0, state=IDLE. Outputs: mem_req=0, stall=0, empty=1. mem_addr and mem_wdata are 0 because the storage array is cleared.
- stall = (count==DEPTH), combinational from the registered count. empty = (count==0).
- Push: memwrite && !stall writes {dataadr, writedata} at wr_ptr; wr_ptr increments modulo DEPTH.
  - Address is stored unchanged; no alignment check.
  - memwrite while stall=1 is not accepted; the core must re-present the store.
- Drain FSM, two states:
  - IDLE: mem_req=0. Go to REQ when count!=0 at the clock edge, i.e. one cycle after the first push into an empty buffer.
  - REQ: mem_req=1. mem_addr and mem_wdata come combinationally from the entry at rd_ptr and stay stable while mem_req=1 and mem_ack=0.
  - On mem_ack in REQ: pop (rd_ptr+1 modulo DEPTH). Next state is REQ if the post-update count is nonzero, else IDLE. Back-to-back drains therefore have no bubble.
  - mem_ack in IDLE is ignored.
- Simultaneous push and pop: count unchanged and both pointers advance.
  - When full, the push is refused even if mem_ack pops the same cycle, because stall uses the registered count.
- Store ordering is strictly FIFO; every accepted store reaches memory exactly once.
- Reset mid-drain: the pending request is abandoned and buffered stores are lost; mem_req drops asynchronously.
- Pointer wrap-around is natural modulo DEPTH. count distinguishes full from empty.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined:
  - If memwrite=1, count!=0, dataadr equals the tail entry's address, and the tail is not the head currently in REQ, then writedata overwrites the tail data.
  - No allocation occurs and count is unchanged.
  - The store is accepted even when stall=1; stall is then masked for that cycle.
- Undefined: every accepted store allocates a new entry. No address comparator is synthesized.

Decomposition:
- Shared package/header `mips_wb_defs`:
  - WB_DEPTH, WB_AW, WB_DW defaults.
  - FSM state encodings: IDLE=1'b0, REQ=1'b1.
- One natural sub-module, wb_fifo: storage array, pointers and count, with push/pop/full/empty and head/tail outputs.
- The drain FSM and coalesce logic stay in store_write_buffer.

Test Plan:
- Reset, then a single store (memwrite=1, dataadr=32'h52, writedata=32'hFFFF7F02, one cycle), mem_ack tied to 1:
  - mem_req rises the next cycle with mem_addr=32'h52 and mem_wdata=32'hFFFF7F02.
  - The entry pops that cycle; empty=1 the cycle after.
- Four stores to 0x50, 0x54, 0x58, 0x5C with mem_ack=0:
  - count reaches 4 and stall=1.
  - A fifth store is refused and count stays 4.
  - Releasing mem_ack drains entries in order 0x50, 0x54, 0x58, 0x5C on four consecutive cycles.
- Full buffer, memwrite and mem_ack in the same cycle:
  - count goes 4 -> 3 and the push is refused.
  - Re-presented store is accepted the next cycle; count = 4.
- Assert reset mid-drain, with 3 entries and mem_req=1:
  - mem_req=0 and count=0 immediately.
  - No memory write completes after reset.
- With WB_COALESCE_EN, two stores to 0x60 (data 1, then 5) while the head is held at 0x40 with mem_ack=0:
  - count=2 after both stores.
  - Drains 0x40 then 0x60 with data 5.
- Without the macro, the same stimulus gives count=3 and drains 0x40, 0x60/1, 0x60/5.
